// File: rtl/trig_cordic.sv
// Iterative CORDIC sine/cosine generator: a 16-bit binary angle in, signed Q8.8 sine/cosine out.
// One shared micro-rotation datapath runs ITER cycles per request.
module trig_cordic #(
  parameter int ITER = 12
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [15:0]        angle_in,
  input  logic               start_in,
  output logic signed [15:0] sin_val_out,
  output logic signed [15:0] cos_val_out,
  output logic               valid_out,
  output logic               busy_out
);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t state, state_nxt;

  logic signed [17:0] x, y, z;
  logic [3:0]         iter;
  logic               flip;

  logic signed [17:0] x_sh, y_sh, atan_i;
  logic signed [17:0] s_full, c_full;
  logic [15:0]        z0;
  logic               fold;
  logic               last_iter;

  function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 18'sd8192;
      4'd1:    return 18'sd4836;
      4'd2:    return 18'sd2555;
      4'd3:    return 18'sd1297;
      4'd4:    return 18'sd651;
      4'd5:    return 18'sd326;
      4'd6:    return 18'sd163;
      4'd7:    return 18'sd81;
      4'd8:    return 18'sd41;
      4'd9:    return 18'sd20;
      4'd10:   return 18'sd10;
      4'd11:   return 18'sd5;
      4'd12:   return 18'sd3;
      4'd13:   return 18'sd1;
      default: return 18'sd0;
    endcase
  endfunction

  // Quadrants II and III are rotated by 180 degrees; the result is negated at the end.
  assign fold      = angle_in[15] ^ angle_in[14];
  assign z0        = fold ? {~angle_in[15], angle_in[14:0]} : angle_in;
  assign x_sh      = x >>> iter;
  assign y_sh      = y >>> iter;
  assign atan_i    = atan_lut(iter);
  assign last_iter = (iter == 4'(ITER - 1));
  assign s_full    = (y + 18'sd32) >>> 6;
  assign c_full    = (x + 18'sd32) >>> 6;
  assign busy_out  = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = ROTATE;
      ROTATE:  if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // x starts at K*2^14 so the accumulated CORDIC gain is cancelled up front.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x           <= '0;
      y           <= '0;
      z           <= '0;
      iter        <= '0;
      flip        <= 1'b0;
      sin_val_out <= 16'sd0;
      cos_val_out <= 16'sd256;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            x    <= 18'sd9949;
            y    <= 18'sd0;
            z    <= {{2{z0[15]}}, z0};
            iter <= '0;
            flip <= fold;
          end
        end
        ROTATE: begin
          if (!z[17]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_i;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_i;
          end
          if (!last_iter) iter <= iter + 4'd1;
        end
        DONE: begin
          sin_val_out <= 16'(flip ? -s_full : s_full);
          cos_val_out <= 16'(flip ? -c_full : c_full);
          valid_out   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_cordic.sv
// Self-checking bench for trig_cordic: table vectors, corner-case sequences and a
// back-to-back sweep, all scored through a queue of expected results.
module tb_trig_cordic;

  localparam int ITER = 12;
  localparam int LAT  = ITER + 1;
  localparam int TOL  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [15:0]        angle = 16'd0;
  logic signed [15:0] sinv, cosv;
  logic               valid, busy;

  trig_cordic #(.ITER(ITER)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .angle_in    (angle),
    .start_in    (start),
    .sin_val_out (sinv),
    .cos_val_out (cosv),
    .valid_out   (valid),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int angle;
    int expSin;
    int expCos;
    int startEdge;
  } sbItem_t;

  typedef struct {
    logic [15:0] angle;
    int          expSin;
    int          expCos;
  } vec_t;

  sbItem_t sbq[$];
  vec_t    vecs[7];
  int      nChecks = 0;
  int      nFails = 0;
  int      validCount = 0;

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    nChecks++;
    if (actual > expected + tol || actual < expected - tol) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, actual, expected, tol, cyc);
    end
  endtask

  function automatic int golden(input int a, input bit isSin);
    real th;
    real v;
    th = a * 2.0 * 3.14159265358979 / 65536.0;
    v  = isSin ? 256.0 * $sin(th) : 256.0 * $cos(th);
    return $rtoi($floor(v + 0.5));
  endfunction

  // Every valid pulse must match the oldest outstanding request, exactly LAT edges after its start.
  always @(negedge clk) begin
    if (valid) begin
      sbItem_t item;
      validCount++;
      if (sbq.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_valid: got valid with sin=%0d cos=%0d, expected none", sinv, cosv);
      end else begin
        item = sbq.pop_front();
        checkOutput($sformatf("sin(%0d)", item.angle), int'(sinv), item.expSin, TOL);
        checkOutput($sformatf("cos(%0d)", item.angle), int'(cosv), item.expCos, TOL);
        checkOutput($sformatf("latency(%0d)", item.angle), cyc - item.startEdge, LAT, 0);
      end
    end
  end

  // Called just after a rising edge; leaves the bench just after the edge that samples start.
  task automatic applyStimulus(input logic [15:0] a, input int es, input int ec, input bit expectResult);
    sbItem_t item;
    angle = a;
    start = 1'b1;
    if (expectResult) begin
      item.angle     = int'(a);
      item.expSin    = es;
      item.expCos    = ec;
      item.startEdge = cyc + 1;
      sbq.push_back(item);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input int bound, input string name);
    for (int n = 0; n < bound; n++) begin
      @(posedge clk); #1;
      if (valid) return;
    end
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: got no valid within %0d cycles, expected one", name, bound);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0, busyLow, prevValid;

    vecs[0] = '{16'd0,     0,    256};
    vecs[1] = '{16'd16384, 256,  0};
    vecs[2] = '{16'd8192,  181,  181};
    vecs[3] = '{16'd40960, -181, -181};
    vecs[4] = '{16'd32768, 0,    -256};
    vecs[5] = '{16'd49152, -256, 0};
    vecs[6] = '{16'd54613, -222, 128};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sin", int'(sinv), 0, 0);
    checkOutput("reset_cos", int'(cosv), 256, 0);
    checkOutput("reset_valid", int'(valid), 0, 0);
    checkOutput("reset_busy", int'(busy), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].angle, vecs[i].expSin, vecs[i].expCos, 1'b1);
      waitValid(LAT + 5, "vec_valid");
      @(posedge clk); #1;
    end

    // A second start five edges in must be ignored while busy stays high.
    v0 = validCount;
    busyLow = 0;
    applyStimulus(16'd8192, 181, 181, 1'b1);
    for (int k = 0; k < ITER; k++) begin
      if (!busy) busyLow++;
      if (k == 4) begin
        angle = 16'd16384;
        start = 1'b1;
      end
      if (k == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    if (!busy) busyLow++;
    @(posedge clk); #1;
    checkOutput("busy_valid_pulse", int'(valid), 1, 0);
    checkOutput("busy_low_at_valid", int'(busy), 0, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy_held_high", busyLow, 0, 0);
    checkOutput("single_result", validCount - v0, 1, 0);

    // Reset partway through rotation discards the request.
    v0 = validCount;
    applyStimulus(16'd8192, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_sin", int'(sinv), 0, 0);
    checkOutput("midrst_cos", int'(cosv), 256, 0);
    checkOutput("midrst_busy", int'(busy), 0, 0);
    checkOutput("midrst_valid", int'(valid), 0, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst_no_valid", validCount - v0, 0, 0);
    applyStimulus(16'd16384, 256, 0, 1'b1);
    waitValid(LAT + 5, "post_reset_valid");
    @(posedge clk); #1;

    // Reset and start together: reset wins.
    v0 = validCount;
    angle = 16'd8192;
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", int'(busy), 0, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rst_start_no_valid", validCount - v0, 0, 0);

    // A start in the valid cycle is sampled one edge later, so results land LAT+1 edges apart.
    prevValid = 0;
    for (int k = 0; k < 256; k++) begin
      int a;
      a = k * 256;
      applyStimulus(16'(a), golden(a, 1'b1), golden(a, 1'b0), 1'b1);
      waitValid(LAT + 5, "sweep_valid");
      if (k > 0) checkOutput("sweep_spacing", cyc - prevValid, LAT + 1, 0);
      prevValid = cyc;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sbq.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
